// File: rtl/gray_readout.sv
// Purpose : column readout sequencer; walks pixel code memories 0..N_PIXELS-1,
//           converts each stored gray code to binary and streams it out.
// Latency : pix_rd to out_valid is 2 cycles (3 with GRAY_READOUT_PIPE_EN).
// Backpressure: out_data/out_addr are held in OUT until out_ready; no new read
//           is issued until the current result has been accepted.
//
// Optional build macro: GRAY_READOUT_PIPE_EN registers pix_data (gray_q) before
// the gray-to-binary XOR chain and adds a CONV state, for timing at large WIDTH.
//
// Ports:
//   clk, reset      - rising-edge clock; asynchronous active-high reset
//   start           - begin a frame readout (only sampled in IDLE)
//   pix_addr/pix_rd - pixel memory address and one-cycle read strobe
//   pix_data        - gray code returned the cycle after pix_rd
//   out_data/out_addr/out_valid/out_ready - binary result stream, valid/ready
//   busy            - high whenever not IDLE
//   done            - one-cycle pulse after the last pixel has been accepted
module gray_readout #(
    parameter int N_PIXELS = 4,
    parameter int WIDTH    = 8,
    localparam int AW      = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [AW-1:0]    pix_addr,
    output logic             pix_rd,
    input  logic [WIDTH-1:0] pix_data,
    output logic [WIDTH-1:0] out_data,
    output logic [AW-1:0]    out_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_CONV = 3'd3,
        S_OUT  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [AW-1:0] LAST_K = AW'(N_PIXELS - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [AW-1:0]    out_addr_q, out_addr_d;

    // Inverse of the conversion counter encoding g[i] = q[i] ^ q[i+1]:
    // each binary bit is the XOR of all gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

`ifdef GRAY_READOUT_PIPE_EN
    logic [WIDTH-1:0] gray_q, gray_d;
`endif

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        out_data_d = out_data_q;
        out_addr_d = out_addr_q;
`ifdef GRAY_READOUT_PIPE_EN
        gray_d     = gray_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d     = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
`ifdef GRAY_READOUT_PIPE_EN
                gray_d     = pix_data;
                state_d    = S_CONV;
`else
                out_data_d = gray2bin(pix_data);
                out_addr_d = k_q;
                state_d    = S_OUT;
`endif
            end
`ifdef GRAY_READOUT_PIPE_EN
            S_CONV: begin
                out_data_d = gray2bin(gray_q);
                out_addr_d = k_q;
                state_d    = S_OUT;
            end
`endif
            S_OUT: begin
                // Result is held here until accepted; only then move on.
                if (out_ready) begin
                    if (k_q == LAST_K) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + AW'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            out_data_q <= out_data_d;
            out_addr_q <= out_addr_d;
        end
    end

`ifdef GRAY_READOUT_PIPE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end
`endif

    // Status outputs are decoded straight from the state register, so an
    // asynchronous reset clears them in the same cycle.
    assign pix_addr  = k_q;
    assign pix_rd    = (state_q == S_READ);
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_gray_readout.sv
// Purpose : directed bench for gray_readout, one N_PIXELS=1 and one N_PIXELS=4 instance.
// Latency : expectations follow GRAY_READOUT_PIPE_EN (period 3 or 4 cycles).
// Backpressure: out_ready of the 4-pixel instance is stalled for 5 cycles on pixel 1.
module tb_gray_readout;

`ifdef GRAY_READOUT_PIPE_EN
    localparam int P = 4;
`else
    localparam int P = 3;
`endif

    logic       clk = 1'b0;
    logic       reset;
    always #5 clk = ~clk;

    // N_PIXELS = 1 instance
    logic       start1 = 1'b0;
    logic [0:0] pix_addr1;
    logic       pix_rd1;
    logic [7:0] pix_data1 = 8'h00;
    logic [7:0] out_data1;
    logic [0:0] out_addr1;
    logic       out_valid1;
    logic       out_ready1 = 1'b1;
    logic       busy1;
    logic       done1;
    logic [7:0] mem1 = 8'h00;

    // N_PIXELS = 4 instance
    logic       start4 = 1'b0;
    logic [1:0] pix_addr4;
    logic       pix_rd4;
    logic [7:0] pix_data4 = 8'h00;
    logic [7:0] out_data4;
    logic [1:0] out_addr4;
    logic       out_valid4;
    logic       out_ready4 = 1'b1;
    logic       busy4;
    logic       done4;
    logic [7:0] mem4 [4];
    logic [7:0] exp4 [4];

    int total = 0;
    int bad   = 0;

    gray_readout #(.N_PIXELS(1), .WIDTH(8)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .pix_addr(pix_addr1), .pix_rd(pix_rd1), .pix_data(pix_data1),
        .out_data(out_data1), .out_addr(out_addr1), .out_valid(out_valid1),
        .out_ready(out_ready1), .busy(busy1), .done(done1)
    );

    gray_readout #(.N_PIXELS(4), .WIDTH(8)) dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .pix_addr(pix_addr4), .pix_rd(pix_rd4), .pix_data(pix_data4),
        .out_data(out_data4), .out_addr(out_addr4), .out_valid(out_valid4),
        .out_ready(out_ready4), .busy(busy4), .done(done4)
    );

    // Pixel code memories: data returned the cycle after the read strobe.
    always @(posedge clk) begin
        if (pix_rd1) pix_data1 <= mem1;
        if (pix_rd4) pix_data4 <= mem4[pix_addr4];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame on the single-pixel instance; start is sampled at the next edge.
    task automatic conv1(input logic [7:0] g, input logic [7:0] e, input string tag, input bit full);
        int n;
        mem1   = g;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        n = 1;
        while (!out_valid1 && n < 10) begin
            step();
            n++;
        end
        chk(tag, {24'h0, out_data1}, {24'h0, e});
        if (full) begin
            chk({tag, "_cycle"}, n, P);
            chk({tag, "_addr"}, {31'h0, out_addr1}, 32'h0);
        end
        step();
        if (full) chk({tag, "_done"}, {31'h0, done1}, 32'h1);
        step();
    endtask

    initial begin
        int n;
        int dcnt;
        bit saw3;
        logic [7:0] g8;

        mem4[0] = 8'h05; exp4[0] = 8'h06;
        mem4[1] = 8'h80; exp4[1] = 8'hFF;
        mem4[2] = 8'hC0; exp4[2] = 8'h80;
        mem4[3] = 8'h0F; exp4[3] = 8'h0A;

        // ---------------- reset state ----------------
        reset = 1'b1;
        step(); step(); step();
        chk("rst_pix_addr", {30'h0, pix_addr4}, 0);
        chk("rst_pix_rd",   {31'h0, pix_rd4}, 0);
        chk("rst_out_data", {24'h0, out_data4}, 0);
        chk("rst_out_addr", {30'h0, out_addr4}, 0);
        chk("rst_out_valid",{31'h0, out_valid4}, 0);
        chk("rst_busy",     {31'h0, busy4}, 0);
        chk("rst_done",     {31'h0, done4}, 0);
        chk("rst_busy1",    {31'h0, busy1}, 0);
        reset = 1'b0;
        step();

        // ---------------- conversion vectors, N_PIXELS=1 ----------------
        conv1(8'h00, 8'h00, "conv_00", 1'b1);
        conv1(8'h01, 8'h01, "conv_01", 1'b1);
        conv1(8'h03, 8'h02, "conv_03", 1'b1);
        conv1(8'h80, 8'hFF, "conv_80", 1'b1);
        conv1(8'hC0, 8'h80, "conv_C0", 1'b1);

        // ---------------- full frame timing, N_PIXELS=4 ----------------
        out_ready4 = 1'b1;
        start4 = 1'b1;
        step();               // edge 0 sampled; now in cycle 1
        start4 = 1'b0;
        for (int c = 1; c <= 4 * P + 2; c++) begin
            chk("frame_valid", {31'h0, out_valid4}, {31'h0, (c % P == 0) && (c <= 4 * P)});
            chk("frame_rd",    {31'h0, pix_rd4},    {31'h0, (c % P == 1) && (c <= 3 * P + 1)});
            chk("frame_done",  {31'h0, done4},      {31'h0, c == 4 * P + 1});
            chk("frame_busy",  {31'h0, busy4},      {31'h0, c <= 4 * P + 1});
            if ((c % P == 0) && (c <= 4 * P)) begin
                chk("frame_addr", {30'h0, out_addr4}, c / P - 1);
                chk("frame_data", {24'h0, out_data4}, {24'h0, exp4[c / P - 1]});
            end
            step();
        end

        // ---------------- backpressure + ignored start ----------------
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        n = 0;
        while (!(pix_rd4 && pix_addr4 == 2'd1) && n < 20) begin
            step();
            n++;
        end
        chk("bp_read1_seen", {31'h0, pix_rd4 && pix_addr4 == 2'd1}, 1);
        out_ready4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 20) begin
            step();
            n++;
        end
        chk("bp_valid1_seen", {31'h0, out_valid4}, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", {31'h0, out_valid4}, 1);
            chk("bp_hold_data",  {24'h0, out_data4}, 32'hFF);
            chk("bp_hold_addr",  {30'h0, out_addr4}, 1);
            chk("bp_no_read",    {31'h0, pix_rd4}, 0);
            if (i == 4) out_ready4 = 1'b1;
            step();
        end
        chk("bp_read2_rd",   {31'h0, pix_rd4}, 1);
        chk("bp_read2_addr", {30'h0, pix_addr4}, 2);
        start4 = 1'b1;        // ignored: block is busy on pixel 2
        step();
        start4 = 1'b0;
        n = 0; dcnt = 0; saw3 = 1'b0;
        while (busy4 && n < 40) begin
            if (done4) dcnt++;
            if (out_valid4 && out_addr4 == 2'd3 && out_data4 == 8'h0A) saw3 = 1'b1;
            step();
            n++;
        end
        chk("ign_idle_reached", {31'h0, busy4}, 0);
        chk("ign_done_count", dcnt, 1);
        chk("ign_pixel3_out", {31'h0, saw3}, 1);
        step(); step();
        chk("ign_no_restart", {31'h0, busy4}, 0);

        // ---------------- reset mid-frame ----------------
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        n = 0;
        while (!(pix_rd4 && pix_addr4 == 2'd1) && n < 20) begin
            step();
            n++;
        end
        chk("mr_read1_seen", {31'h0, pix_rd4 && pix_addr4 == 2'd1}, 1);
        step();               // WAIT of pixel 1
        chk("mr_pre_data", {24'h0, out_data4}, 32'h06);
        #2 reset = 1'b1;
        #1;
        chk("mr_pix_addr",  {30'h0, pix_addr4}, 0);
        chk("mr_pix_rd",    {31'h0, pix_rd4}, 0);
        chk("mr_out_data",  {24'h0, out_data4}, 0);
        chk("mr_out_addr",  {30'h0, out_addr4}, 0);
        chk("mr_out_valid", {31'h0, out_valid4}, 0);
        chk("mr_busy",      {31'h0, busy4}, 0);
        chk("mr_done",      {31'h0, done4}, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("mr_hold_done", {31'h0, done4}, 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_stay_idle", {31'h0, busy4}, 0);
            chk("mr_no_done",   {31'h0, done4}, 0);
        end
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        chk("mr_restart_rd",   {31'h0, pix_rd4}, 1);
        chk("mr_restart_addr", {30'h0, pix_addr4}, 0);
        n = 0;
        while (!out_valid4 && n < 20) begin
            step();
            n++;
        end
        chk("mr_first_addr", {30'h0, out_addr4}, 0);
        chk("mr_first_data", {24'h0, out_data4}, 32'h06);
        n = 0;
        while (busy4 && n < 40) begin
            step();
            n++;
        end
        chk("mr_drain_idle", {31'h0, busy4}, 0);

        // ---------------- every counter value through its gray code ----------------
        for (int q = 0; q < 256; q++) begin
            g8 = 8'(q) ^ (8'(q) >> 1);
            conv1(g8, 8'(q), "gray_all", 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_readout.md
# gray_readout

Column readout sequencer for the single-slope ADC array. Once the shared gray-code conversion counter has been latched into each pixel's code memory, this block walks the pixel memories in address order. It reads each stored gray code, converts it to binary and streams the binary results out over a valid/ready interface towards the chip output/serialiser. Scheduling: it runs after a conversion completes, between the pixel array and the output stage.

## Interface
Parameters:
- N_PIXELS, 4, number of pixel memories read per frame (≥1)
- WIDTH, 8, code width; must equal the conversion counter width
- AW, $clog2(N_PIXELS) with minimum 1, address width (derived, not overridden)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- start  in  1  begin readout of pixels 0..N_PIXELS-1; sampled only in IDLE
- pix_addr  out  AW  address of pixel memory being read
- pix_rd  out  1  read strobe to pixel memory, one cycle per pixel
- pix_data  in  WIDTH  gray code from the addressed pixel, valid the cycle after pix_rd
- out_data  out  WIDTH  binary code, registered
- out_addr  out  AW  pixel index belonging to out_data
- out_valid  out  1  out_data/out_addr valid
- out_ready  in  1  consumer accepts when out_valid && out_ready at a rising edge
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse after the last pixel is accepted

## Operation
- States: IDLE, READ, WAIT, [CONV], OUT, DONE.
- IDLE: start=1 sets pixel index k=0 and moves to READ; otherwise remain.
- READ: pix_rd=1, pix_addr=k; next state WAIT.
- WAIT: pix_data is valid.
  - Without macro: out_data <= gray2bin(pix_data), out_addr <= k, next OUT.
  - With macro: gray_q <= pix_data, next CONV.
- CONV (macro only): out_data <= gray2bin(gray_q), out_addr <= k, next OUT.
- OUT: out_valid=1. out_data and out_addr are held stable until accepted.
  - On accept with k<N_PIXELS-1: k <= k+1, next READ.
  - On accept with k=N_PIXELS-1: next DONE.
- DONE: done=1 for one cycle, busy still 1; next IDLE.
- gray2bin: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i=WIDTH-2..0. This is the exact inverse of the counter encoding g[i]=q[i]^q[i+1], g[MSB]=q[MSB].
- start outside IDLE is ignored; it does not restart or queue.
- pix_addr holds k in all states. pix_rd is high only in READ.

## Timing
- Reset values: pix_addr=0, pix_rd=0, out_data=0, out_addr=0, out_valid=0, busy=0, done=0. State=IDLE, k=0.
- Reset mid-readout aborts immediately. No done pulse is produced. Readout restarts only on a new start.
- Latency is measured from pix_rd to out_valid: 2 cycles without the macro, 3 with it.
- Per-pixel period with out_ready tied high: 3 cycles without the macro, 4 with it. Each cycle of out_ready low adds one cycle.
- Cycle numbering: start sampled at edge 0; READ in cycle 1; done pulses 1 cycle after the final accept.
- out_valid never deasserts without acceptance. The consumer may hold out_ready high permanently.
- N_PIXELS=1: a single READ/WAIT/OUT pass, then DONE.

## Configuration
- GRAY_READOUT_PIPE_EN defined:
  - Adds the gray_q register and the CONV state.
  - pix_data is registered before the gray2bin XOR chain, for timing closure at large WIDTH.
  - Latency is 3 cycles; period is 4 cycles.
- Not defined:
  - gray2bin is applied directly to pix_data in WAIT.
  - Latency is 2 cycles; period is 3 cycles.
- The output ordering and the handshake are identical in both builds.

## Test plan
- Conversion, one pixel per case, N_PIXELS=1:
  - pix_data 8'h00 -> out_data 8'h00.
  - pix_data 8'h01 -> out_data 8'h01.
  - pix_data 8'h03 -> out_data 8'h02.
  - pix_data 8'h80 -> out_data 8'hFF.
  - pix_data 8'hC0 -> out_data 8'h80.
- Full frame, N_PIXELS=4, out_ready=1, start at edge 0, no macro:
  - out_valid in cycles 3, 6, 9, 12 with out_addr 0..3.
  - done in cycle 13; busy falls in cycle 14.
  - With the macro: out_valid in cycles 4, 8, 12, 16; done in cycle 17.
- Backpressure: hold out_ready=0 for 5 cycles on pixel 1.
  - out_valid stays 1; out_data and out_addr stay unchanged.
  - No pix_rd for pixel 2 until acceptance.
- Ignored start: pulse start during pixel 2 -> the sequence continues to pixel 3, and done pulses exactly once.
- Reset mid-frame: assert reset in WAIT of pixel 1.
  - All outputs return to 0 in the same cycle; no done pulse.
  - A new start then reads from pixel 0.
- Random codes: all 256 gray values of the counter sequence -> out_data equals the original count value for each.
